iir_coeff_loader: RTL and testbench

// Coefficient configuration sequencer for the 3-stage notch IIR chain (2.4 MHz -> 1 MHz -> 2 MHz).
// - Accepts coefficient words from a valid/ready config port and stages them in a shadow bank.
// - Commits the complete 5-coefficient set (b0,b1,b2,a1,a2) to one stage with a single-cycle write enable.
// - Places each commit in a gap in the sample stream, so no sample is filtered with mixed coefficients.
// - Collects sticky overflow/underflow status from all stages.

---
 rtl/iir_coeff_loader.sv | 115 +++++++++++
 tb/tb_iir_coeff_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_loader.sv
// Coefficient loader for the notch IIR chain: stages a 5-word coefficient set in a
// shadow bank and commits it to one stage in a gap of the sample stream.
module iir_coeff_loader #(
  parameter int COEFF_WIDTH = 20,
  parameter int COEFF_DEPTH = 5,
  parameter int NUM_STAGES  = 3,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [1:0]                              cfg_stage,
  input  logic [2:0]                              cfg_idx,
  input  logic [COEFF_WIDTH-1:0]                  cfg_data,
  input  logic                                    cfg_last,
  input  logic                                    valid_in,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_bus,
  output logic [NUM_STAGES-1:0]                   coeff_wr_en,
  output logic                                    commit_done,
  output logic                                    forced,
  output logic                                    cfg_err,
  input  logic [NUM_STAGES-1:0]                   ovf_in,
  input  logic [NUM_STAGES-1:0]                   unf_in,
  output logic [NUM_STAGES-1:0]                   ovf_sticky,
  output logic [NUM_STAGES-1:0]                   unf_sticky,
  input  logic                                    status_clr
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_GAP, COMMIT, DONE} state_t;

  state_t                                 state_reg, state_next;
  logic [1:0]                             burst_stage_reg;
  logic [7:0]                             gap_cnt_reg;
  logic                                   cfg_ready_reg;
  logic                                   forced_reg;
  logic                                   cfg_err_reg;
  logic [NUM_STAGES-1:0]                  ovf_sticky_reg;
  logic [NUM_STAGES-1:0]                  unf_sticky_reg;
  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] shadow_reg;

  logic accept;
  logic word_bad;
  logic word_ok;
  logic force_set;

  assign accept   = cfg_valid & cfg_ready_reg;
  // A stage mismatch only matters once a burst has latched its target.
  assign word_bad = (int'(cfg_stage) >= NUM_STAGES) || (int'(cfg_idx) >= COEFF_DEPTH) ||
                    ((state_reg == LOAD) && (cfg_stage != burst_stage_reg));
  assign word_ok  = accept & ~word_bad;

  always_comb begin
    state_next = state_reg;
    force_set  = 1'b0;
    case (state_reg)
      IDLE:     if (word_ok) state_next = cfg_last ? WAIT_GAP : LOAD;
      LOAD:     if (word_ok && cfg_last) state_next = WAIT_GAP;
      WAIT_GAP: begin
        if (!valid_in) begin
          state_next = COMMIT;
        end else if (gap_cnt_reg == 8'(GAP_TIMEOUT - 1)) begin
          state_next = COMMIT;
          force_set  = 1'b1;
        end
      end
      COMMIT:   state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      burst_stage_reg <= '0;
      gap_cnt_reg     <= '0;
      cfg_ready_reg   <= 1'b0;
      forced_reg      <= 1'b0;
      cfg_err_reg     <= 1'b0;
      ovf_sticky_reg  <= '0;
      unf_sticky_reg  <= '0;
      shadow_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && word_ok) burst_stage_reg <= cfg_stage;
      gap_cnt_reg <= ((state_reg == WAIT_GAP) && (state_next == WAIT_GAP)) ? gap_cnt_reg + 8'd1 : 8'd0;
      // Ready is registered from the next state so it drops together with entry to WAIT_GAP.
      cfg_ready_reg  <= (state_next == IDLE) || (state_next == LOAD);
      forced_reg     <= force_set | (forced_reg & ~status_clr);
      cfg_err_reg    <= (accept & word_bad) | (cfg_err_reg & ~status_clr);
      ovf_sticky_reg <= ovf_in | (ovf_sticky_reg & {NUM_STAGES{~status_clr}});
      unf_sticky_reg <= unf_in | (unf_sticky_reg & {NUM_STAGES{~status_clr}});
      for (int i = 0; i < COEFF_DEPTH; i++) begin
        if (word_ok && (cfg_idx == 3'(i))) shadow_reg[i] <= cfg_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_wr_en
      assign coeff_wr_en[gi] = (state_reg == COMMIT) && (burst_stage_reg == 2'(gi));
    end
  endgenerate

  assign coeff_bus   = shadow_reg;
  assign commit_done = (state_reg == DONE);
  assign cfg_ready   = cfg_ready_reg;
  assign forced      = forced_reg;
  assign cfg_err     = cfg_err_reg;
  assign ovf_sticky  = ovf_sticky_reg;
  assign unf_sticky  = unf_sticky_reg;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed self-checking bench for iir_coeff_loader with hand-computed expectations.
module tb_iir_coeff_loader;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid, cfg_ready, cfg_last, valid_in;
  logic [1:0]       cfg_stage;
  logic [2:0]       cfg_idx;
  logic [19:0]      cfg_data;
  logic [4:0][19:0] coeff_bus;
  logic [2:0]       coeff_wr_en, ovf_in, unf_in, ovf_sticky, unf_sticky;
  logic             commit_done, forced, cfg_err, status_clr;

  int n_tests = 0;
  int n_fail  = 0;

  iir_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_stage(cfg_stage), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .valid_in(valid_in), .coeff_bus(coeff_bus), .coeff_wr_en(coeff_wr_en),
    .commit_done(commit_done), .forced(forced), .cfg_err(cfg_err),
    .ovf_in(ovf_in), .unf_in(unf_in), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
    .status_clr(status_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] st, input logic [2:0] idx, input logic [19:0] d,
                      input logic last);
    cfg_valid = 1'b1; cfg_stage = st; cfg_idx = idx; cfg_data = d; cfg_last = last;
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic burst(input logic [1:0] st, input logic [19:0] v0, input logic [19:0] v1,
                       input logic [19:0] v2, input logic [19:0] v3, input logic [19:0] v4);
    send(st, 3'd0, v0, 1'b0);
    send(st, 3'd1, v1, 1'b0);
    send(st, 3'd2, v2, 1'b0);
    send(st, 3'd3, v3, 1'b0);
    send(st, 3'd4, v4, 1'b1);
  endtask

  task automatic check_bus(input string tag, input logic [19:0] v0, input logic [19:0] v1,
                           input logic [19:0] v2, input logic [19:0] v3, input logic [19:0] v4);
    check({tag, "_b0"}, 32'(coeff_bus[0]), 32'(v0));
    check({tag, "_b1"}, 32'(coeff_bus[1]), 32'(v1));
    check({tag, "_b2"}, 32'(coeff_bus[2]), 32'(v2));
    check({tag, "_a1"}, 32'(coeff_bus[3]), 32'(v3));
    check({tag, "_a2"}, 32'(coeff_bus[4]), 32'(v4));
  endtask

  initial begin
    int waits;
    logic [2:0] wr_seen;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_stage = '0; cfg_idx = '0; cfg_data = '0;
    cfg_last = 1'b0; valid_in = 1'b0; ovf_in = '0; unf_in = '0; status_clr = 1'b0;

    // 1. reset state
    tick(); tick();
    check("rst_wr_en", 32'(coeff_wr_en), 32'd0);
    check("rst_done", 32'(commit_done), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_flags", {28'd0, forced, cfg_err, 2'd0}, 32'd0);
    check("rst_sticky", {26'd0, ovf_sticky, unf_sticky}, 32'd0);
    check_bus("rst_bus", 20'd0, 20'd0, 20'd0, 20'd0, 20'd0);
    rst_n = 1'b1;
    check("ready_before_clk", 32'(cfg_ready), 32'd0);
    tick();
    check("ready_after_clk", 32'(cfg_ready), 32'd1);

    // 2. stage 2 burst, gap already open
    burst(2'd2, 20'h10000, 20'd1, 20'd2, 20'd3, 20'd4);
    check("n1_ready", 32'(cfg_ready), 32'd0);
    check("n1_wr_en", 32'(coeff_wr_en), 32'd0);
    tick();
    check("n2_wr_en", 32'(coeff_wr_en), 32'b100);
    check("n2_done", 32'(commit_done), 32'd0);
    check_bus("n2_bus", 20'h10000, 20'd1, 20'd2, 20'd3, 20'd4);
    tick();
    check("n3_done", 32'(commit_done), 32'd1);
    check("n3_wr_en", 32'(coeff_wr_en), 32'd0);
    tick();
    check("n4_ready", 32'(cfg_ready), 32'd1);
    check("n4_forced", 32'(forced), 32'd0);

    // 3. forced commit after timeout, then a commit on a late gap
    valid_in = 1'b1;
    burst(2'd2, 20'h10000, 20'd1, 20'd2, 20'd3, 20'd4);
    waits = 0;
    while (coeff_wr_en == 3'd0 && waits < 400) begin
      tick();
      waits++;
    end
    check("timeout_waits", 32'(waits), 32'd255);
    check("timeout_wr_en", 32'(coeff_wr_en), 32'b100);
    check("timeout_forced", 32'(forced), 32'd1);
    tick(); tick();
    burst(2'd1, 20'd5, 20'd6, 20'd7, 20'd8, 20'd9);
    wr_seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      wr_seen |= coeff_wr_en;
    end
    check("late_gap_no_wr", 32'(wr_seen), 32'd0);
    valid_in = 1'b0;
    tick();
    check("late_gap_wr_en", 32'(coeff_wr_en), 32'b010);
    check_bus("late_gap_bus", 20'd5, 20'd6, 20'd7, 20'd8, 20'd9);
    tick(); tick();

    // 4. illegal words
    send(2'd3, 3'd2, 20'h33333, 1'b0);
    check("err_stage3", 32'(cfg_err), 32'd1);
    check("err_stage3_ready", 32'(cfg_ready), 32'd1);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check("clr_err", 32'(cfg_err), 32'd0);
    check("clr_forced", 32'(forced), 32'd0);
    send(2'd1, 3'd0, 20'hAAAAA, 1'b0);
    send(2'd1, 3'd6, 20'h11111, 1'b0);
    check("err_idx6", 32'(cfg_err), 32'd1);
    send(2'd0, 3'd1, 20'h22222, 1'b1);
    wr_seen = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_seen |= coeff_wr_en;
    end
    check("err_no_wr", 32'(wr_seen), 32'd0);
    check("err_still_load", 32'(cfg_ready), 32'd1);
    check_bus("err_bus", 20'hAAAAA, 20'd6, 20'd7, 20'd8, 20'd9);

    // 5. sticky status
    ovf_in = 3'b010;
    tick();
    ovf_in = 3'b000;
    check("ovf_set", 32'(ovf_sticky), 32'b010);
    tick();
    check("ovf_held", 32'(ovf_sticky), 32'b010);
    status_clr = 1'b1; unf_in = 3'b001;
    tick();
    status_clr = 1'b0; unf_in = 3'b000;
    check("ovf_cleared", 32'(ovf_sticky), 32'b000);
    check("unf_set_wins", 32'(unf_sticky), 32'b001);
    check("err_cleared", 32'(cfg_err), 32'd0);

    // 6. reset during WAIT_GAP
    valid_in = 1'b1;
    send(2'd1, 3'd4, 20'h44444, 1'b1);
    check("wait_ready", 32'(cfg_ready), 32'd0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(coeff_wr_en), 32'd0);
    check_bus("rst_mid_bus", 20'd0, 20'd0, 20'd0, 20'd0, 20'd0);
    tick();
    rst_n = 1'b1;
    valid_in = 1'b0;
    wr_seen = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      wr_seen |= coeff_wr_en;
    end
    check("post_rst_no_wr", 32'(wr_seen), 32'd0);
    check("post_rst_ready", 32'(cfg_ready), 32'd1);
    check("post_rst_done", 32'(commit_done), 32'd0);
    check_bus("post_rst_bus", 20'd0, 20'd0, 20'd0, 20'd0, 20'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
